// File: rtl/tinybrain_reset_pkg.sv
// Shared definitions for the reset sequencing logic: FSM states and the
// upper bound on the number of sequenced reset domains.
package tinybrain_reset_pkg;

    localparam int MaxDomains = 8;
    // Wide enough to count 0..MaxDomains released domains.
    localparam int RelIdxW = $clog2(MaxDomains + 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } seq_state_e;

endpackage

// File: rtl/rst_sync.sv
// Two-flop reset synchronizer: asserts asynchronously with rst_n, releases
// on the second sys_clk edge after rst_n rises.
module rst_sync (
    input  logic sys_clk,
    input  logic rst_n,
    output logic rst_sync_n
);

    logic [1:0] sync_reg;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], 1'b1};
        end
    end

    assign rst_sync_n = sync_reg[1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: hold every domain in reset, then free them one at a
// time (bit 0 first) and report ready once all are out of reset.
module reset_sequencer
    import tinybrain_reset_pkg::*;
#(
    parameter int NumDomains  = 3,
    parameter int HoldCycles  = 100,
    parameter int StageCycles = 16
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  sw_reset_req,
    output logic                  sw_reset_ack,
    output logic [NumDomains-1:0] domain_reset,
    output logic                  ready
);

    localparam int MaxCycles = (HoldCycles > StageCycles) ? HoldCycles : StageCycles;
    localparam int CntW      = $clog2(MaxCycles + 1);

    logic rst_sync_n;

    rst_sync u_rst_sync (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .rst_sync_n (rst_sync_n)
    );

    seq_state_e             state_reg, state_next;
    logic [CntW-1:0]        cnt_reg, cnt_next;
    logic [RelIdxW-1:0]     rel_reg, rel_next;
    logic [NumDomains-1:0]  domain_reset_reg, domain_reset_next;
    logic                   ready_reg, ready_next;
    logic                   ack_reg, ack_next;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_HOLD;
            cnt_reg          <= '0;
            rel_reg          <= '0;
            domain_reset_reg <= '1;
            ready_reg        <= 1'b0;
            ack_reg          <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            rel_reg          <= rel_next;
            domain_reset_reg <= domain_reset_next;
            ready_reg        <= ready_next;
            ack_reg          <= ack_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rel_next   = rel_reg;
        ack_next   = 1'b0;

        // Until the synchronized reset releases, the sequencer stays parked
        // at the start of HOLD and ignores software requests.
        if (!rst_sync_n) begin
            state_next = ST_HOLD;
            cnt_next   = '0;
            rel_next   = '0;
        end else if (sw_reset_req) begin
            state_next = ST_HOLD;
            cnt_next   = '0;
            rel_next   = '0;
            ack_next   = 1'b1;
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    if (cnt_reg == CntW'(HoldCycles - 1)) begin
                        cnt_next   = '0;
                        rel_next   = RelIdxW'(1);
                        state_next = (NumDomains == 1) ? ST_RUN : ST_RELEASE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_reg == CntW'(StageCycles - 1)) begin
                        cnt_next = '0;
                        rel_next = rel_reg + 1'b1;
                        if (rel_reg == RelIdxW'(NumDomains - 1)) begin
                            state_next = ST_RUN;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                    rel_next   = '0;
                end
            endcase
        end

        // Thermometer code: the lowest rel_next domains are out of reset.
        domain_reset_next = {NumDomains{1'b1}} << rel_next;
        ready_next        = (state_next == ST_RUN);
    end

    assign domain_reset = domain_reset_reg;
    assign ready        = ready_reg;
    assign sw_reset_ack = ack_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: spec-derived vector table, directed
// corner sequences and a randomized run against a timing-arithmetic model.
module tb_reset_sequencer;

    localparam int NI = 3;

    logic          sys_clk = 1'b0;
    logic [NI-1:0] rst_n_v;
    logic [NI-1:0] req_v;
    logic [NI-1:0] ack_v;
    logic [NI-1:0] ready_v;
    logic [2:0]    dom0;
    logic [0:0]    dom1;
    logic [3:0]    dom2;

    initial forever #5 sys_clk = ~sys_clk;

    reset_sequencer dut0 (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n_v[0]),
        .sw_reset_req (req_v[0]),
        .sw_reset_ack (ack_v[0]),
        .domain_reset (dom0),
        .ready        (ready_v[0])
    );

    reset_sequencer #(.NumDomains(1), .HoldCycles(1), .StageCycles(16)) dut1 (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n_v[1]),
        .sw_reset_req (req_v[1]),
        .sw_reset_ack (ack_v[1]),
        .domain_reset (dom1),
        .ready        (ready_v[1])
    );

    reset_sequencer #(.NumDomains(4), .HoldCycles(5), .StageCycles(3)) dut2 (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n_v[2]),
        .sw_reset_req (req_v[2]),
        .sw_reset_ack (ack_v[2]),
        .domain_reset (dom2),
        .ready        (ready_v[2])
    );

    function automatic int nd(input int i);
        case (i)
            0: return 3;
            1: return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int hc(input int i);
        case (i)
            0: return 100;
            1: return 1;
            default: return 5;
        endcase
    endfunction

    function automatic int sc(input int i);
        case (i)
            0: return 16;
            1: return 16;
            default: return 3;
        endcase
    endfunction

    function automatic int req_odds(input int i);
        case (i)
            0: return 300;
            1: return 5;
            default: return 30;
        endcase
    endfunction

    function automatic logic [7:0] dut_dom(input int i);
        case (i)
            0: return {5'b0, dom0};
            1: return {7'b0, dom1};
            default: return {4'b0, dom2};
        endcase
    endfunction

    typedef struct {
        int         ph;
        int         e;
        logic       req;
        logic [7:0] dom;
        logic       rdy;
        logic       ack;
    } vec_t;

    function automatic vec_t mk(input int ph, input int e, input logic req,
                                input logic [7:0] dom, input logic rdy, input logic ack);
        vec_t v;
        v.ph = ph; v.e = e; v.req = req; v.dom = dom; v.rdy = rdy; v.ack = ack;
        return v;
    endfunction

    // Reference model: per instance, the edge at which the latest HOLD began
    // and how many synchronizer edges have elapsed since rst_n rose.
    int sync_cnt [NI];
    int start_e  [NI];
    bit ack_exp  [NI];
    int ec;
    int base;
    int checks;
    int errors;

    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            if (!rst_n_v[i]) begin
                sync_cnt[i] = 0;
                ack_exp[i]  = 1'b0;
            end else begin
                ack_exp[i] = (sync_cnt[i] >= 2) && req_v[i];
                if (ack_exp[i]) start_e[i] = ec;
                if (sync_cnt[i] < 2) begin
                    sync_cnt[i]++;
                    if (sync_cnt[i] == 2) start_e[i] = ec;
                end
            end
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < NI; i++) begin
            bit         synced;
            int         k;
            int         full;
            int         x;
            logic [7:0] exp_dom;
            logic [7:0] act;
            logic       exp_rdy;
            logic       exp_ack;
            synced = rst_n_v[i] && (sync_cnt[i] >= 2);
            k = 0;
            if (synced) begin
                for (int j = 0; j < nd(i); j++) begin
                    if (ec >= start_e[i] + hc(i) + j * sc(i)) k++;
                end
            end
            full    = (1 << nd(i)) - 1;
            exp_dom = 8'(full & ~((1 << k) - 1));
            exp_rdy = synced && (k == nd(i));
            exp_ack = rst_n_v[i] && ack_exp[i];
            act     = dut_dom(i);
            checks++;
            if ({act, ready_v[i], ack_v[i]} !== {exp_dom, exp_rdy, exp_ack}) begin
                errors++;
                $display("FAIL model_i%0d edge %0d: dom=%b ready=%b ack=%b, expected dom=%b ready=%b ack=%b",
                         i, ec, act, ready_v[i], ack_v[i], exp_dom, exp_rdy, exp_ack);
            end
            x = full & ~int'(act);
            checks++;
            if (((x & (x + 1)) != 0) || (ready_v[i] !== (act == 8'd0))) begin
                errors++;
                $display("FAIL thermo_i%0d edge %0d: dom=%b ready=%b, required thermometer code and ready==(dom==0)",
                         i, ec, act, ready_v[i]);
            end
        end
    endtask

    // Advance to just after edge e, updating and checking the model each edge.
    task automatic go(input int e);
        while (ec < e) begin
            @(posedge sys_clk);
            ec++;
            model_edge();
            #1;
            check_model();
        end
    endtask

    task automatic expect_dut(input string name, input int i, input logic [7:0] dom,
                              input logic rdy, input logic ack);
        logic [7:0] act;
        act = dut_dom(i);
        checks++;
        $display("%s i%0d edge %0d: dom=%b ready=%b ack=%b", name, i, ec - base, act, ready_v[i], ack_v[i]);
        if ({act, ready_v[i], ack_v[i]} !== {dom, rdy, ack}) begin
            errors++;
            $display("FAIL %s i%0d edge %0d: dom=%b ready=%b ack=%b, expected dom=%b ready=%b ack=%b",
                     name, i, ec - base, act, ready_v[i], ack_v[i], dom, rdy, ack);
        end
    endtask

    // Hold instance i in reset, then release rst_n just after relative edge 0.
    task automatic start_phase(input int i);
        rst_n_v[i]  = 1'b0;
        req_v[i]    = 1'b0;
        sync_cnt[i] = 0;
        ack_exp[i]  = 1'b0;
        go(ec + 2);
        base       = ec;
        rst_n_v[i] = 1'b1;
    endtask

    task automatic pulse_rst(input int i);
        rst_n_v[i]  = 1'b0;
        sync_cnt[i] = 0;
        ack_exp[i]  = 1'b0;
        #1;
        expect_dut("rst_pulse", i, 8'((1 << nd(i)) - 1), 1'b0, 1'b0);
        #1;
        rst_n_v[i] = 1'b1;
    endtask

    initial begin
        vec_t vecs[$];
        int   cur_ph;
        rst_n_v  = '0;
        req_v    = '0;
        ec       = -1;
        base     = 0;
        checks   = 0;
        errors   = 0;
        for (int i = 0; i < NI; i++) begin
            sync_cnt[i] = 0;
            start_e[i]  = 0;
            ack_exp[i]  = 1'b0;
        end

        // Power-up release, then a request in RUN.
        vecs.push_back(mk(0,   1, 1'b0, 8'b111, 1'b0, 1'b0));
        vecs.push_back(mk(0, 101, 1'b0, 8'b111, 1'b0, 1'b0));
        vecs.push_back(mk(0, 102, 1'b0, 8'b110, 1'b0, 1'b0));
        vecs.push_back(mk(0, 117, 1'b0, 8'b110, 1'b0, 1'b0));
        vecs.push_back(mk(0, 118, 1'b0, 8'b100, 1'b0, 1'b0));
        vecs.push_back(mk(0, 133, 1'b0, 8'b100, 1'b0, 1'b0));
        vecs.push_back(mk(0, 134, 1'b0, 8'b000, 1'b1, 1'b0));
        vecs.push_back(mk(0, 199, 1'b0, 8'b000, 1'b1, 1'b0));
        vecs.push_back(mk(0, 200, 1'b1, 8'b111, 1'b0, 1'b1));
        vecs.push_back(mk(0, 201, 1'b0, 8'b111, 1'b0, 1'b0));
        vecs.push_back(mk(0, 299, 1'b0, 8'b111, 1'b0, 1'b0));
        vecs.push_back(mk(0, 300, 1'b0, 8'b110, 1'b0, 1'b0));
        // Request in the middle of RELEASE.
        vecs.push_back(mk(1, 109, 1'b0, 8'b110, 1'b0, 1'b0));
        vecs.push_back(mk(1, 110, 1'b1, 8'b111, 1'b0, 1'b1));
        vecs.push_back(mk(1, 111, 1'b0, 8'b111, 1'b0, 1'b0));
        vecs.push_back(mk(1, 209, 1'b0, 8'b111, 1'b0, 1'b0));
        vecs.push_back(mk(1, 210, 1'b0, 8'b110, 1'b0, 1'b0));
        vecs.push_back(mk(1, 226, 1'b0, 8'b100, 1'b0, 1'b0));
        vecs.push_back(mk(1, 242, 1'b0, 8'b000, 1'b1, 1'b0));

        cur_ph = -1;
        foreach (vecs[v]) begin
            if (vecs[v].ph != cur_ph) begin
                start_phase(0);
                cur_ph = vecs[v].ph;
            end
            go(base + vecs[v].e - 1);
            req_v[0] = vecs[v].req;
            go(base + vecs[v].e);
            expect_dut($sformatf("vec%0d", v), 0, vecs[v].dom, vecs[v].rdy, vecs[v].ack);
            req_v[0] = 1'b0;
        end

        // Request held high for ten edges in RUN.
        start_phase(0);
        go(base + 149);
        expect_dut("held_pre", 0, 8'b000, 1'b1, 1'b0);
        req_v[0] = 1'b1;
        for (int e = 150; e <= 159; e++) begin
            go(base + e);
            expect_dut("held", 0, 8'b111, 1'b0, 1'b1);
        end
        req_v[0] = 1'b0;
        go(base + 160);
        expect_dut("held_drop", 0, 8'b111, 1'b0, 1'b0);
        go(base + 258);
        expect_dut("held_258", 0, 8'b111, 1'b0, 1'b0);
        go(base + 259);
        expect_dut("held_259", 0, 8'b110, 1'b0, 1'b0);

        // Short rst_n pulse between edges 120 and 121.
        start_phase(0);
        go(base + 120);
        expect_dut("pulse_pre", 0, 8'b100, 1'b0, 1'b0);
        pulse_rst(0);
        go(base + 121);
        expect_dut("pulse_121", 0, 8'b111, 1'b0, 1'b0);
        go(base + 221);
        expect_dut("pulse_221", 0, 8'b111, 1'b0, 1'b0);
        go(base + 222);
        expect_dut("pulse_222", 0, 8'b110, 1'b0, 1'b0);
        go(base + 238);
        expect_dut("pulse_238", 0, 8'b100, 1'b0, 1'b0);
        go(base + 254);
        expect_dut("pulse_254", 0, 8'b000, 1'b1, 1'b0);

        // Single domain, single hold cycle: release one edge after t0.
        start_phase(1);
        go(base + 2);
        expect_dut("one_t0", 1, 8'b1, 1'b0, 1'b0);
        go(base + 3);
        expect_dut("one_t1", 1, 8'b0, 1'b1, 1'b0);

        start_phase(2);
        // Randomized requests and reset pulses on all instances.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NI; i++) begin
                req_v[i] = ($urandom_range(0, req_odds(i)) == 0);
                if ($urandom_range(0, 999) == 0) pulse_rst(i);
            end
            go(ec + 1);
        end
        req_v = '0;
        go(ec + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
